// File: rtl/debounce_pkg.sv
// Shared types and limits for the debounce/synchronizer blocks.
package debounce_pkg;

    typedef enum logic {ST_STABLE, ST_PENDING} db_state_t;

    localparam int SYNC_MIN = 2;
    localparam int SYNC_MAX = 4;

endpackage

// File: rtl/sync_ff_chain.sv
// Generic multi-flop synchronizer for a single asynchronous bit.
// Reset loads every stage with RST_VAL.
module sync_ff_chain #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] stage_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= {STAGES{RST_VAL}};
        end else begin
            stage_q <= {stage_q[STAGES-2:0], d};
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Synchronizes and debounces a raw 1-bit input; q follows only after a level holds.
// Optional registered rise/fall pulses are enabled by defining DEBOUNCE_EDGE_EN.
module debounce_sync
    import debounce_pkg::*;
#(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 16,
    parameter logic RST_VAL         = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_raw,
    output logic q,
    output logic qb,
    output logic busy,
    output logic rise,
    output logic fall
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX || DEBOUNCE_CYCLES < 2) begin : g_bad_param
        $error("debounce_sync: SYNC_STAGES must be 2..4 and DEBOUNCE_CYCLES >= 2");
    end

    logic             s_in;
    db_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             q_q, q_d;

    sync_ff_chain #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (RST_VAL)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (d_raw),
        .q   (s_in)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            q_q     <= RST_VAL;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
        end
    end

    // Any return of s_in to q's level drops back to STABLE with a cleared count.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        q_d     = q_q;
        case (state_q)
            ST_STABLE: begin
                if (s_in != q_q) begin
                    state_d = ST_PENDING;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_PENDING: begin
                if (s_in == q_q) begin
                    state_d = ST_STABLE;
                end else if (cnt_q == CNT_LAST) begin
                    q_d     = s_in;
                    state_d = ST_STABLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_STABLE;
            end
        endcase
    end

    assign q    = q_q;
    assign qb   = ~q_q;
    assign busy = (state_q == ST_PENDING);

`ifdef DEBOUNCE_EDGE_EN
    logic rise_q, fall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= q_d & ~q_q;
            fall_q <= ~q_d & q_q;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// Directed, table-driven bench for debounce_sync (SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
// Expected rise/fall pulses are masked off unless DEBOUNCE_EDGE_EN is defined.
module tb_debounce_sync;

`ifdef DEBOUNCE_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    typedef struct {
        logic d;
        logic exp_q;
        logic exp_busy;
        logic exp_rise;
        logic exp_fall;
    } vec_t;

    logic clk;
    logic rst;
    logic d_raw;
    logic q, qb, busy, rise, fall;

    int tests_run;
    int tests_failed;

    vec_t vecs[$];

    debounce_sync #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .RST_VAL         (1'b0)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .d_raw (d_raw),
        .q     (q),
        .qb    (qb),
        .busy  (busy),
        .rise  (rise),
        .fall  (fall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic actual, input logic expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got %b expected %b at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic eq, input logic eb,
                             input logic er, input logic ef);
        check({tag, ".q"},    q,    eq);
        check({tag, ".qb"},   qb,   ~eq);
        check({tag, ".busy"}, busy, eb);
        check({tag, ".rise"}, rise, er & EDGE_EN);
        check({tag, ".fall"}, fall, ef & EDGE_EN);
    endtask

    // One row per clock; strings are read left to right, one character per edge.
    task automatic add_seg(input string d, input string eq, input string eb,
                           input string er, input string ef);
        vec_t v;
        for (int i = 0; i < d.len(); i++) begin
            v.d        = (d[i]  == "1");
            v.exp_q    = (eq[i] == "1");
            v.exp_busy = (eb[i] == "1");
            v.exp_rise = (er[i] == "1");
            v.exp_fall = (ef[i] == "1");
            vecs.push_back(v);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;

        //       d_raw          q              busy           rise           fall
        add_seg("11111111",    "00000111",    "00111000",    "00000100",    "00000000");    // clean rise
        add_seg("00000000",    "11111000",    "00111000",    "00000000",    "00000100");    // clean fall
        add_seg("11000000",    "00000000",    "00110000",    "00000000",    "00000000");    // glitch
        add_seg("10101111111", "00000000011", "00101011100", "00000000010", "00000000000"); // bounce
        add_seg("00000000",    "11111000",    "00111000",    "00000000",    "00000100");    // fall again

        // Reset held for one cycle
        rst   = 1'b1;
        d_raw = 1'b0;
        @(posedge clk);
        #1;
        check_all("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        $display("[TB] reset: q=%b qb=%b busy=%b rise=%b fall=%b", q, qb, busy, rise, fall);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            d_raw = vecs[i].d;
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].exp_q, vecs[i].exp_busy,
                      vecs[i].exp_rise, vecs[i].exp_fall);
            $display("[TB] vec%0d d=%b -> q=%b busy=%b rise=%b fall=%b", i, vecs[i].d,
                     q, busy, rise, fall);
        end

        // Reset asserted asynchronously while a rise is being qualified
        @(negedge clk);
        d_raw = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("midrst.busy_before", busy, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_all("midrst.during", 1'b0, 1'b0, 1'b0, 1'b0);
        $display("[TB] midrst during: q=%b busy=%b", q, busy);
        @(negedge clk);
        rst = 1'b0;

        // Full requalification from the reset chain values with d_raw still high
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk);
            #1;
            check_all($sformatf("requal%0d", k), (k >= 6), (k >= 3 && k <= 5), (k == 6), 1'b0);
            $display("[TB] requal edge %0d: q=%b busy=%b rise=%b", k, q, busy, rise);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
